// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl
// Sequencer for a bank of KERNEL_W+1 line buffers that feed a
// KERNEL_W x KERNEL_W sliding-window stage. One RESOLUTION x RESOLUTION
// frame is accepted as a valid/ready pixel stream. The pixel data goes
// straight to the buffers and does not pass through this block. The
// controller does the following:
//   - steers writes round-robin across the buffers,
//   - clears each buffer's pointers before the buffer is reused,
//   - issues read-advance strobes to the KERNEL_W buffers that hold
//     complete lines,
//   - reports the kernel-row to buffer mapping, the window position and
//     end of frame.
//
// Optional build macro: LB_CTRL_STATS_EN adds the stall_cnt_o and
// frame_cnt_o statistics outputs.
//
// Ports:
//   clk_i, arst_n_i    clock, asynchronous active-low reset
//   in_valid_i/o_ready pixel stream handshake (in_ready_o is registered)
//   buf_wr_valid_o     one-hot write strobe to the buffer being filled
//   buf_rd_valid_o     read-advance strobe to the KERNEL_W read buffers
//   buf_srst_o         one-cycle pointer clear, per buffer
//   row_sel_o          buffer index of kernel row k at [k*SEL_W +: SEL_W]
//   out_valid_o/out_ready_i  window handshake
//   out_row_o/out_col_o      window position
//   eof_o              pulse after the last window has been consumed
//   busy_o             high whenever the sequencer is not idle
//   stall_cnt_o, frame_cnt_o (LB_CTRL_STATS_EN only)
module linebuf_ctrl #(
   parameter  int KERNEL_W   = 3,
   parameter  int RESOLUTION = 512,
   localparam int NUM_BUF    = KERNEL_W + 1,
   localparam int SEL_W      = $clog2(NUM_BUF),
   localparam int CNT_W      = $clog2(RESOLUTION + 1)
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic [NUM_BUF-1:0]        buf_wr_valid_o,
   output logic [NUM_BUF-1:0]        buf_rd_valid_o,
   output logic [NUM_BUF-1:0]        buf_srst_o,
   output logic [KERNEL_W*SEL_W-1:0] row_sel_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [CNT_W-1:0]          out_row_o,
   output logic [CNT_W-1:0]          out_col_o,
   output logic                      eof_o,
`ifdef LB_CTRL_STATS_EN
   output logic [31:0]               stall_cnt_o,
   output logic [15:0]               frame_cnt_o,
`endif
   output logic                      busy_o
);

   localparam int OUT_W = RESOLUTION - KERNEL_W + 1;
   localparam logic [CNT_W-1:0] RES_C   = CNT_W'(RESOLUTION);
   localparam logic [CNT_W-1:0] RES_M1  = CNT_W'(RESOLUTION - 1);
   localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] K_C     = CNT_W'(KERNEL_W);
   localparam logic [SEL_W-1:0] K_SEL   = SEL_W'(KERNEL_W);
   localparam logic [SEL_W-1:0] ONE_SEL = SEL_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_ROT, S_DRAIN} state_t;

   // (a + b) mod NUM_BUF for operands already below NUM_BUF
   function automatic logic [SEL_W-1:0] add_mod(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W-1:0] b);
      logic [SEL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (SEL_W+1)'(NUM_BUF)) s = s - (SEL_W+1)'(NUM_BUF);
      return s[SEL_W-1:0];
   endfunction

   state_t                     state_reg, state_next;
   logic [CNT_W-1:0]           wr_col_reg, wr_col_next;
   logic [CNT_W-1:0]           wr_row_reg, wr_row_next;
   logic [CNT_W-1:0]           rd_col_reg, rd_col_next;
   logic [CNT_W-1:0]           out_row_reg, out_row_next;
   logic [SEL_W-1:0]           base_reg, base_next;
   logic                       init_reg;
   logic                       in_ready_reg, in_ready_next;
   logic                       out_valid_reg, out_valid_next;
   logic                       eof_reg, eof_next;
   logic [NUM_BUF-1:0]         srst_reg, srst_next;
   logic [KERNEL_W*SEL_W-1:0]  row_sel_reg, row_sel_next, row_sel_rst;
   logic [NUM_BUF-1:0]         base_onehot;
   logic [SEL_W-1:0]           spare_sel, wr_sel;
   logic                       accept, rd_fire;

   assign accept    = in_valid_i & in_ready_reg;
   assign rd_fire   = out_valid_reg & out_ready_i;
   // The buffer that is not being read is always base+KERNEL_W.
   assign spare_sel = add_mod(base_reg, K_SEL);
   // While filling, wr_row < KERNEL_W < NUM_BUF, so its low bits are enough.
   assign wr_sel    = (state_reg == S_RUN) ? spare_sel
                                           : add_mod(base_reg, wr_row_reg[SEL_W-1:0]);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUF; gi++) begin : g_buf
         assign buf_wr_valid_o[gi] = accept & (wr_sel == SEL_W'(gi));
         assign buf_rd_valid_o[gi] = rd_fire & (spare_sel != SEL_W'(gi));
         assign base_onehot[gi]    = (base_reg == SEL_W'(gi));
      end
      for (gi = 0; gi < KERNEL_W; gi++) begin : g_row
         assign row_sel_next[gi*SEL_W +: SEL_W] = add_mod(base_next, SEL_W'(gi));
         assign row_sel_rst[gi*SEL_W +: SEL_W]  = SEL_W'(gi);
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      wr_col_next  = wr_col_reg;
      wr_row_next  = wr_row_reg;
      rd_col_next  = rd_col_reg;
      out_row_next = out_row_reg;
      base_next    = base_reg;
      eof_next     = 1'b0;
      srst_next    = '0;
      case (state_reg)
         S_IDLE, S_FILL: begin
            if (accept) begin
               if (wr_col_reg == RES_M1) begin
                  wr_col_next = '0;
                  wr_row_next = wr_row_reg + 1'b1;
                  if ((wr_row_reg + 1'b1) == K_C)
                     state_next = (RESOLUTION > KERNEL_W) ? S_RUN : S_DRAIN;
                  else
                     state_next = S_FILL;
               end else begin
                  wr_col_next = wr_col_reg + 1'b1;
                  state_next  = S_FILL;
               end
            end
         end
         S_RUN: begin
            // The spare line fills independently of the window reads.
            if (accept) begin
               wr_col_next = wr_col_reg + 1'b1;
               if (wr_col_reg == RES_M1) wr_row_next = wr_row_reg + 1'b1;
            end
            if (rd_fire) rd_col_next = rd_col_reg + 1'b1;
            if (wr_col_reg == RES_C && rd_col_reg == OUT_W_C) begin
               state_next = S_ROT;
               // The clear is visible during ROT, when the oldest buffer is idle.
               srst_next  = base_onehot;
            end
         end
         S_ROT: begin
            base_next    = add_mod(base_reg, ONE_SEL);
            wr_col_next  = '0;
            rd_col_next  = '0;
            out_row_next = out_row_reg + 1'b1;
            state_next   = (wr_row_reg == RES_C) ? S_DRAIN : S_RUN;
         end
         S_DRAIN: begin
            if (rd_fire) rd_col_next = rd_col_reg + 1'b1;
            if (rd_col_reg == OUT_W_C) begin
               state_next   = S_IDLE;
               eof_next     = 1'b1;
               srst_next    = '1;
               base_next    = '0;
               wr_col_next  = '0;
               wr_row_next  = '0;
               rd_col_next  = '0;
               out_row_next = '0;
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (init_reg) srst_next = '1;
      // in_ready is held low while a clear is pulsed, so that no write can
      // coincide with a pointer clear on the same buffer.
      in_ready_next  = ((state_next == S_IDLE) && (srst_next == '0)) ||
                       (state_next == S_FILL) ||
                       ((state_next == S_RUN) && (wr_col_next < RES_C));
      out_valid_next = ((state_next == S_RUN) || (state_next == S_DRAIN)) &&
                       (rd_col_next < OUT_W_C);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_reg     <= S_IDLE;
         wr_col_reg    <= '0;
         wr_row_reg    <= '0;
         rd_col_reg    <= '0;
         out_row_reg   <= '0;
         base_reg      <= '0;
         init_reg      <= 1'b1;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         eof_reg       <= 1'b0;
         srst_reg      <= '0;
         row_sel_reg   <= row_sel_rst;
      end else begin
         state_reg     <= state_next;
         wr_col_reg    <= wr_col_next;
         wr_row_reg    <= wr_row_next;
         rd_col_reg    <= rd_col_next;
         out_row_reg   <= out_row_next;
         base_reg      <= base_next;
         init_reg      <= 1'b0;
         in_ready_reg  <= in_ready_next;
         out_valid_reg <= out_valid_next;
         eof_reg       <= eof_next;
         srst_reg      <= srst_next;
         row_sel_reg   <= row_sel_next;
      end
   end

   assign in_ready_o  = in_ready_reg;
   assign out_valid_o = out_valid_reg;
   assign eof_o       = eof_reg;
   assign buf_srst_o  = srst_reg;
   assign row_sel_o   = row_sel_reg;
   assign out_row_o   = out_row_reg;
   assign out_col_o   = rd_col_reg;
   assign busy_o      = (state_reg != S_IDLE);

`ifdef LB_CTRL_STATS_EN
   logic [31:0] stall_cnt_reg;
   logic [15:0] frame_cnt_reg;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         stall_cnt_reg <= '0;
         frame_cnt_reg <= '0;
      end else begin
         if (state_reg == S_IDLE && accept)
            stall_cnt_reg <= '0;
         else if (out_valid_reg && !out_ready_i)
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (eof_reg) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
   assign frame_cnt_o = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_linebuf_ctrl.sv
// tb_linebuf_ctrl
// This bench checks linebuf_ctrl in two configurations:
//   - RESOLUTION=8, KERNEL_W=3 (dut),
//   - RESOLUTION=3, KERNEL_W=3 (dut3).
// The start-up sequence is checked from a table of vectors. Whole frames
// are checked against a small raster model of pixel and window order.
module tb_linebuf_ctrl;
   localparam int RES = 8;
   localparam int K   = 3;
   localparam int NB  = 4;
   localparam int OW  = RES - K + 1;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       in_valid, in_ready, out_valid, out_ready, eof, busy;
   logic [3:0] wr_valid, rd_valid, srst;
   logic [5:0] row_sel;
   logic [3:0] out_row, out_col;

   logic       iv3, ir3, ov3, or3, eof3, busy3;
   logic [3:0] wr3, rd3, srst3;
   logic [5:0] rs3;
   logic [1:0] orow3, ocol3;

`ifdef LB_CTRL_STATS_EN
   logic [31:0] stall_cnt, stall_cnt3;
   logic [15:0] frame_cnt, frame_cnt3;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   linebuf_ctrl #(.KERNEL_W(K), .RESOLUTION(RES)) dut (
      .clk_i(clk), .arst_n_i(arst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .buf_wr_valid_o(wr_valid), .buf_rd_valid_o(rd_valid), .buf_srst_o(srst),
      .row_sel_o(row_sel), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_row_o(out_row), .out_col_o(out_col), .eof_o(eof),
`ifdef LB_CTRL_STATS_EN
      .stall_cnt_o(stall_cnt), .frame_cnt_o(frame_cnt),
`endif
      .busy_o(busy));

   linebuf_ctrl #(.KERNEL_W(3), .RESOLUTION(3)) dut3 (
      .clk_i(clk), .arst_n_i(arst_n), .in_valid_i(iv3), .in_ready_o(ir3),
      .buf_wr_valid_o(wr3), .buf_rd_valid_o(rd3), .buf_srst_o(srst3),
      .row_sel_o(rs3), .out_valid_o(ov3), .out_ready_i(or3),
      .out_row_o(orow3), .out_col_o(ocol3), .eof_o(eof3),
`ifdef LB_CTRL_STATS_EN
      .stall_cnt_o(stall_cnt3), .frame_cnt_o(frame_cnt3),
`endif
      .busy_o(busy3));

   typedef struct {
      logic       iv;
      logic       exp_rdy;
      logic [3:0] exp_wr;
      logic [3:0] exp_srst;
      logic       exp_busy;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Expected mapping {row2,row1,row0} for base b
   function automatic logic [5:0] map_sel(input int b);
      return {2'((b + 2) % NB), 2'((b + 1) % NB), 2'(b % NB)};
   endfunction

   function automatic logic [3:0] rd_mask(input int b);
      logic [3:0] m;
      m = 4'hF;
      m[(b + K) % NB] = 1'b0;
      return m;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      arst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // mode 0: always valid/ready, 1: 20-cycle output stall, 2: random
   task automatic run_frame(input int mode, input int stop_pix, input string tag);
      int pix, win, er, ec, nsr, stall_left;
      bit stalled, done;
      logic [3:0] exp_w;
      logic [3:0] sr_seen [8];
      logic [3:0] exp_sr [6];
      exp_sr = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'hF};
      pix = 0; win = 0; er = 0; ec = 0; nsr = 0; stall_left = 0;
      stalled = 0; done = 0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         if (mode == 1) begin
            if (win == 8 && !stalled) begin stalled = 1; stall_left = 20; end
            in_valid = 1'b1; out_ready = (stall_left == 0);
         end else if (mode == 2) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid = 1'b1; out_ready = 1'b1;
         end
         #1;
         exp_w = '0;
         if (in_valid && in_ready) exp_w[(pix / RES) % NB] = 1'b1;
         chk({tag, "_wr"}, wr_valid, exp_w);
         if (out_valid && out_ready) begin
            chk({tag, "_row"}, out_row, er);
            chk({tag, "_col"}, out_col, ec);
            chk({tag, "_rowsel"}, row_sel, map_sel(er % NB));
            chk({tag, "_rdmask"}, rd_valid, rd_mask(er % NB));
            chk({tag, "_lines_full"}, pix >= (er + K) * RES, 1);
            $display("%s window %0d row=%0d col=%0d sel=%0h", tag, win, out_row, out_col, row_sel);
            win++; ec++;
            if (ec == OW) begin ec = 0; er++; end
         end else begin
            chk({tag, "_rd_idle"}, rd_valid, 0);
         end
         if (mode == 1 && stall_left == 1) chk({tag, "_spare_full_ready"}, in_ready, 0);
         if (stall_left > 0) stall_left--;
         if (in_valid && in_ready) pix++;
         if (srst != 0 && nsr < 8) begin sr_seen[nsr] = srst; nsr++; end
         if (eof) begin
            chk({tag, "_eof_busy"}, busy, 0);
            chk({tag, "_pixels"}, pix, RES * RES);
            chk({tag, "_windows"}, win, OW * OW);
            done = 1;
         end
         if (stop_pix != 0 && pix == stop_pix) done = 1;
         if (!done) @(negedge clk);
      end
      chk({tag, "_completed"}, done, 1);
      if (stop_pix == 0 && done) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         chk({tag, "_idle_ready"}, in_ready, 1);
         chk({tag, "_idle_busy"}, busy, 0);
         chk({tag, "_eof_single"}, eof, 0);
         chk({tag, "_srst_count"}, nsr, 6);
         for (int i = 0; i < 6; i++) chk({tag, "_srst_seq"}, sr_seen[i], exp_sr[i]);
      end
   endtask

   initial begin
      int pix3, win3;
      bit done3;
      logic [3:0] w3;

      arst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; iv3 = 1'b0; or3 = 1'b1;

      // Table of start-up vectors: {in_valid, in_ready, wr strobe, srst, busy}
      tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b0};
      for (int i = 4; i <= 10; i++) tbl[i] = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 4'h2, 4'h0, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_eof", eof, 0);
      chk("rst_srst", srst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rowsel", row_sel, 6'h24);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_col", out_col, 0);
      @(negedge clk);
      arst_n = 1'b1;
      for (int i = 0; i < 13; i++) begin
         in_valid = tbl[i].iv;
         #1;
         chk("tbl_in_ready", in_ready, tbl[i].exp_rdy);
         chk("tbl_wr", wr_valid, tbl[i].exp_wr);
         chk("tbl_srst", srst, tbl[i].exp_srst);
         chk("tbl_busy", busy, tbl[i].exp_busy);
         chk("tbl_rowsel", row_sel, 6'h24);
         chk("tbl_out_valid", out_valid, 0);
         $display("vec %0d iv=%0b rdy=%0b wr=%0h srst=%0h busy=%0b",
                  i, in_valid, in_ready, wr_valid, srst, busy);
         @(negedge clk);
      end

      do_reset();
      run_frame(0, 0, "full");
      do_reset();
      run_frame(1, 0, "stall");
      do_reset();
      run_frame(2, 0, "rand");

      // Asynchronous reset in the middle of a frame
      do_reset();
      run_frame(0, 30, "abort");
      #1 arst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_wr", wr_valid, 0);
      chk("abort_srst", srst, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_col", out_col, 0);
      chk("abort_rowsel", row_sel, 6'h24);
      $display("abort reset applied at pixel 30");
      do_reset();
      run_frame(0, 0, "post_abort");

      // RES=3: FILL goes straight to DRAIN with a single window
      pix3 = 0; win3 = 0; done3 = 0;
      for (int c = 0; c < 200 && !done3; c++) begin
         iv3 = 1'b1; or3 = 1'b1;
         #1;
         w3 = '0;
         if (iv3 && ir3) w3[(pix3 / 3) % NB] = 1'b1;
         chk("r3_wr", wr3, w3);
         if (ov3 && or3) begin
            chk("r3_lines_full", pix3, 9);
            chk("r3_row", orow3, 0);
            chk("r3_col", ocol3, 0);
            chk("r3_rdmask", rd3, 4'h7);
            $display("r3 window %0d row=%0d col=%0d", win3, orow3, ocol3);
            win3++;
         end
         if (iv3 && ir3) pix3++;
         if (eof3) begin
            chk("r3_windows", win3, 1);
            chk("r3_pixels", pix3, 9);
            chk("r3_srst", srst3, 4'hF);
            done3 = 1;
         end
         if (!done3) @(negedge clk);
      end
      chk("r3_completed", done3, 1);
      @(negedge clk);
      iv3 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
